// File: rtl/edit_distance_pkg.sv
// Shared types and arithmetic helpers for the edit_distance_scan engine.
// Functions work on a fixed maximum width; callers zero-extend their
// operands and truncate the result back to their own distance width.
package edit_distance_pkg;

  // Widest distance/symbol value the helper functions can carry.
  localparam int ED_MAXW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ed_state_e;

  // a + b clamped to maxv (maxv is the all-ones value of the caller's width).
  function automatic logic [ED_MAXW-1:0] sat_add(
    input logic [ED_MAXW-1:0] a,
    input logic [ED_MAXW-1:0] b,
    input logic [ED_MAXW-1:0] maxv
  );
    logic [ED_MAXW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, maxv}) begin
      return maxv;
    end
    return s[ED_MAXW-1:0];
  endfunction

  function automatic logic [ED_MAXW-1:0] min3(
    input logic [ED_MAXW-1:0] a,
    input logic [ED_MAXW-1:0] b,
    input logic [ED_MAXW-1:0] c
  );
    logic [ED_MAXW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  // One DP cell: min(up+1, left+1, diag + (x==y ? 0 : sub_cost)), all saturating.
  function automatic logic [ED_MAXW-1:0] cell_update(
    input logic [ED_MAXW-1:0] left,
    input logic [ED_MAXW-1:0] diag,
    input logic [ED_MAXW-1:0] up,
    input logic [ED_MAXW-1:0] x,
    input logic [ED_MAXW-1:0] y,
    input logic [ED_MAXW-1:0] sub_cost,
    input logic [ED_MAXW-1:0] maxv
  );
    logic [ED_MAXW-1:0] one;
    logic [ED_MAXW-1:0] cost;
    one  = {{(ED_MAXW-1){1'b0}}, 1'b1};
    cost = (x == y) ? '0 : sub_cost;
    return min3(sat_add(up, one, maxv),
                sat_add(left, one, maxv),
                sat_add(diag, cost, maxv));
  endfunction

endpackage

// File: rtl/edit_distance_row.sv
// One DP row stage. Takes row i-1 of the distance table, consumes the
// oldest remaining window symbol, and registers row i together with the
// valid flag, the text index and the still-unconsumed window symbols.
// Row vector packing: column j lives at bits [j*DISTW +: DISTW].
module edit_distance_row
  import edit_distance_pkg::*;
#(
  parameter int P        = 16,
  parameter int DW       = 2,
  parameter int DISTW    = 6,
  parameter int IDXW     = 32,
  parameter int SUB_COST = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [IDXW-1:0]         i_idx,
  input  logic [(P+1)*DISTW-1:0]  i_row,
  input  logic [P*DW-1:0]         i_win,
  input  logic [P*DW-1:0]         i_pat,
  output logic                    o_valid,
  output logic [IDXW-1:0]         o_idx,
  output logic [(P+1)*DISTW-1:0]  o_row,
  output logic [P*DW-1:0]         o_win
);

  localparam logic [DISTW-1:0]   MAXD = '1;
  localparam logic [ED_MAXW-1:0] MAXV = ED_MAXW'(MAXD);
  localparam logic [ED_MAXW-1:0] SUBV = ED_MAXW'(SUB_COST);

  logic [(P+1)*DISTW-1:0] w_next;
  logic [DW-1:0]          w_sym;

  // Column chain for this row: column 0 is the previous row's column 0 plus one,
  // every further column depends on the one just computed to its left.
  always_comb begin
    logic [DISTW-1:0] v_left;
    w_sym  = i_win[DW-1:0];
    w_next = '0;
    v_left = DISTW'(sat_add(ED_MAXW'(i_row[DISTW-1:0]), ED_MAXW'(1), MAXV));
    w_next[DISTW-1:0] = v_left;
    for (int j = 1; j <= P; j++) begin
      v_left = DISTW'(cell_update(ED_MAXW'(v_left),
                                  ED_MAXW'(i_row[(j-1)*DISTW +: DISTW]),
                                  ED_MAXW'(i_row[j*DISTW +: DISTW]),
                                  ED_MAXW'(w_sym),
                                  ED_MAXW'(i_pat[(j-1)*DW +: DW]),
                                  SUBV, MAXV));
      w_next[j*DISTW +: DISTW] = v_left;
    end
  end

  // Stage register: row result plus the payload travelling alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_idx   <= '0;
      o_row   <= '0;
      o_win   <= '0;
    end else begin
      o_valid <= i_valid;
      o_idx   <= i_idx;
      o_row   <= w_next;
      o_win   <= i_win >> DW;
    end
  end

endmodule

// File: rtl/edit_distance_scan.sv
// Streaming approximate-match engine. Holds a P-symbol pattern and, for each
// accepted text symbol once P symbols are available, reports the weighted
// edit distance between the pattern and the last P text symbols.
// Pipeline: window register -> capture register -> P row stages, so a result
// appears P+1 cycles after its launching handshake.
// Text handshake: a symbol transfers on a rising edge where i_txt_valid and
// o_txt_ready are both high; o_txt_ready is high exactly in RUN. There is no
// output backpressure.
// Optional feature: define EDIT_DISTANCE_BEST_EN to build the best-match
// tracker; otherwise o_best_* are held at their reset values.
module edit_distance_scan
  import edit_distance_pkg::*;
#(
  parameter int P        = 16,
  parameter int DW       = 2,
  parameter int DISTW    = 6,
  parameter int IDXW     = 32,
  parameter int SUB_COST = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pat_we,
  input  logic [$clog2(P)-1:0]  i_pat_addr,
  input  logic [DW-1:0]         i_pat_data,
  input  logic                  i_start,
  output logic                  o_busy,
  input  logic                  i_txt_valid,
  output logic                  o_txt_ready,
  input  logic [DW-1:0]         i_txt_data,
  input  logic                  i_txt_last,
  output logic                  o_res_valid,
  output logic [IDXW-1:0]       o_res_idx,
  output logic [DISTW-1:0]      o_res_dist,
  output logic                  o_done,
  output logic                  o_best_valid,
  output logic [IDXW-1:0]       o_best_idx,
  output logic [DISTW-1:0]      o_best_dist,
  output logic [1:0]            o_state
);

  localparam int               FW   = $clog2(P+1);
  localparam int               RW   = (P+1)*DISTW;
  localparam logic [DISTW-1:0] MAXD = '1;

  ed_state_e          r_state;
  logic [P*DW-1:0]    r_pat;
  logic [P*DW-1:0]    r_win;
  logic [FW-1:0]      r_fill;
  logic [IDXW-1:0]    r_idx;
  logic               r_l_valid;
  logic [IDXW-1:0]    r_l_idx;
  logic               r_c_valid;
  logic [IDXW-1:0]    r_c_idx;
  logic [P*DW-1:0]    r_c_win;

  logic               w_hs;
  logic               w_launch;
  logic               w_start_ok;
  logic               w_empty;
  logic [RW-1:0]      w_row0;
  logic [RW-1:0]      w_row [0:P];
  logic [P*DW-1:0]    w_win [0:P];
  logic               w_v   [0:P];
  logic [IDXW-1:0]    w_idx [0:P];
  logic               w_unused_tail;

  assign w_hs       = (r_state == ST_RUN) && i_txt_valid;
  assign w_launch   = w_hs && (r_fill >= FW'(P-1));
  assign w_start_ok = (r_state == ST_IDLE) && i_start && !i_pat_we;

  assign o_txt_ready = (r_state == ST_RUN);
  assign o_busy      = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign o_done      = (r_state == ST_DONE);
  assign o_state     = r_state;

  // Sequencing: IDLE -> RUN on start, RUN -> FLUSH on accepted last symbol,
  // FLUSH -> DONE once no result is in flight, DONE -> IDLE after one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start_ok) r_state <= ST_RUN;
        ST_RUN:   if (w_hs && i_txt_last) r_state <= ST_FLUSH;
        ST_FLUSH: if (w_empty) r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Pattern storage; writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= '0;
    end else if ((r_state == ST_IDLE) && i_pat_we) begin
      r_pat[int'(i_pat_addr)*DW +: DW] <= i_pat_data;
    end
  end

  // Text window, fill count and index counter. Start also empties the window
  // so a new stream never matches against symbols of the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win     <= '0;
      r_fill    <= '0;
      r_idx     <= '0;
      r_l_valid <= 1'b0;
      r_l_idx   <= '0;
    end else begin
      r_l_valid <= w_launch;
      if (w_start_ok) begin
        r_win  <= '0;
        r_fill <= '0;
        r_idx  <= '0;
      end else if (w_hs) begin
        r_win   <= {i_txt_data, r_win[P*DW-1:DW]};
        r_l_idx <= r_idx;
        r_idx   <= r_idx + 1'b1;
        if (r_fill != FW'(P)) r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Capture stage: snapshot of the freshly shifted window for launched results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_idx   <= '0;
      r_c_win   <= '0;
    end else begin
      r_c_valid <= r_l_valid;
      r_c_idx   <= r_l_idx;
      r_c_win   <= r_win;
    end
  end

  // DP row 0: D[0][j] = j, clamped to the distance range.
  always_comb begin
    w_row0 = '0;
    for (int j = 0; j <= P; j++) begin
      w_row0[j*DISTW +: DISTW] = (j > int'(MAXD)) ? MAXD : DISTW'(j);
    end
  end

  assign w_row[0] = w_row0;
  assign w_win[0] = r_c_win;
  assign w_v[0]   = r_c_valid;
  assign w_idx[0] = r_c_idx;

  for (genvar g = 0; g < P; g++) begin : g_row
    edit_distance_row #(
      .P(P), .DW(DW), .DISTW(DISTW), .IDXW(IDXW), .SUB_COST(SUB_COST)
    ) u_row (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_v[g]),
      .i_idx   (w_idx[g]),
      .i_row   (w_row[g]),
      .i_win   (w_win[g]),
      .i_pat   (r_pat),
      .o_valid (w_v[g+1]),
      .o_idx   (w_idx[g+1]),
      .o_row   (w_row[g+1]),
      .o_win   (w_win[g+1])
    );
  end

  // Pipeline occupancy, used to hold FLUSH until the last result has left.
  always_comb begin
    w_empty = !(r_l_valid || r_c_valid);
    for (int k = 1; k <= P; k++) begin
      if (w_v[k]) w_empty = 1'b0;
    end
  end

  assign o_res_valid = w_v[P];
  assign o_res_idx   = w_idx[P];
  assign o_res_dist  = w_row[P][RW-1 -: DISTW];

  // Only the final column of the last row is a result; the rest is discarded.
  assign w_unused_tail = ^{w_row[P][RW-DISTW-1:0], w_win[P]};

`ifdef EDIT_DISTANCE_BEST_EN
  logic              r_best_valid;
  logic [IDXW-1:0]   r_best_idx;
  logic [DISTW-1:0]  r_best_dist;

  // Best-match tracker: strictly smaller distance wins, so ties keep the earliest.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_best_valid <= 1'b0;
      r_best_idx   <= '0;
      r_best_dist  <= '1;
    end else if (o_res_valid && (!r_best_valid || (o_res_dist < r_best_dist))) begin
      r_best_valid <= 1'b1;
      r_best_idx   <= o_res_idx;
      r_best_dist  <= o_res_dist;
    end
  end

  assign o_best_valid = r_best_valid;
  assign o_best_idx   = r_best_idx;
  assign o_best_dist  = r_best_dist;
`else
  assign o_best_valid = 1'b0;
  assign o_best_idx   = '0;
  assign o_best_dist  = '1;
`endif

endmodule

// File: tb/tb_edit_distance_scan.sv
// Bench for edit_distance_scan with P=4, DW=2, SUB_COST=2. Two instances share
// all inputs: one with DISTW=6 and one with DISTW=2 (saturating distances).
// The reference model is a plain edit-distance table over the accepted text.
module tb_edit_distance_scan;

  localparam int TP  = 4;
  localparam int TIW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic            pat_we, start, txt_valid, txt_last;
  logic [1:0]      pat_addr, pat_data, txt_data;
  logic            busy, txt_ready, res_valid, done, best_valid;
  logic [TIW-1:0]  res_idx, best_idx;
  logic [5:0]      res_dist, best_dist;
  logic [1:0]      state;
  logic            s_busy, s_txt_ready, s_res_valid, s_done, s_best_valid;
  logic [TIW-1:0]  s_res_idx, s_best_idx;
  logic [1:0]      s_res_dist, s_best_dist;
  logic [1:0]      s_state;

  edit_distance_scan #(.P(TP), .DW(2), .DISTW(6), .IDXW(TIW), .SUB_COST(2)) dut (
    .clk(clk), .rst(rst), .i_pat_we(pat_we), .i_pat_addr(pat_addr), .i_pat_data(pat_data),
    .i_start(start), .o_busy(busy), .i_txt_valid(txt_valid), .o_txt_ready(txt_ready),
    .i_txt_data(txt_data), .i_txt_last(txt_last), .o_res_valid(res_valid), .o_res_idx(res_idx),
    .o_res_dist(res_dist), .o_done(done), .o_best_valid(best_valid), .o_best_idx(best_idx),
    .o_best_dist(best_dist), .o_state(state)
  );

  edit_distance_scan #(.P(TP), .DW(2), .DISTW(2), .IDXW(TIW), .SUB_COST(2)) dut_sat (
    .clk(clk), .rst(rst), .i_pat_we(pat_we), .i_pat_addr(pat_addr), .i_pat_data(pat_data),
    .i_start(start), .o_busy(s_busy), .i_txt_valid(txt_valid), .o_txt_ready(s_txt_ready),
    .i_txt_data(txt_data), .i_txt_last(txt_last), .o_res_valid(s_res_valid), .o_res_idx(s_res_idx),
    .o_res_dist(s_res_dist), .o_done(s_done), .o_best_valid(s_best_valid), .o_best_idx(s_best_idx),
    .o_best_dist(s_best_dist), .o_state(s_state)
  );

  // ---------------- scoreboard state ----------------
  // entry: {expected negedge cycle[71:40], idx[39:8], dist DISTW=6 [7:2], dist DISTW=2 [1:0]}
  logic [71:0] exp_q[$];
  logic [71:0] mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;

  int          mpat[TP];
  int          hist[$];
  int          stim[$];
  bit          best_v;
  int          best_i, best_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic int ref_dist(input int w[TP], input int p[TP], input int maxv);
    int d[TP+1][TP+1];
    int a, b, c;
    for (int i = 0; i <= TP; i++) d[i][0] = sat(i, maxv);
    for (int j = 0; j <= TP; j++) d[0][j] = sat(j, maxv);
    for (int i = 1; i <= TP; i++) begin
      for (int j = 1; j <= TP; j++) begin
        a = sat(d[i-1][j] + 1, maxv);
        b = sat(d[i][j-1] + 1, maxv);
        c = sat(d[i-1][j-1] + ((w[i-1] == p[j-1]) ? 0 : 2), maxv);
        d[i][j] = (a < b) ? a : b;
        if (c < d[i][j]) d[i][j] = c;
      end
    end
    return d[TP][TP];
  endfunction

  // Record an accepted symbol; c is the cycle count at the negedge before the handshake edge.
  task automatic model_accept(input int sym, input int c);
    int w[TP];
    int d6, d2, n;
    hist.push_back(sym);
    n = hist.size();
    if (n >= TP) begin
      for (int k = 0; k < TP; k++) w[k] = hist[n-TP+k];
      d6 = ref_dist(w, mpat, 63);
      d2 = ref_dist(w, mpat, 3);
      // P+1 edges after the handshake edge -> visible at the negedge with cycle c+P+2
      exp_q.push_back({32'(c + TP + 2), 32'(n - 1), 6'(d6), 2'(d2)});
      if (!best_v || d6 < best_d) begin
        best_v = 1'b1;
        best_i = n - 1;
        best_d = d6;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_pattern(input int p0, input int p1, input int p2, input int p3, input bit with_start);
    int p[TP];
    p = '{p0, p1, p2, p3};
    for (int j = 0; j < TP; j++) begin
      @(negedge clk);
      pat_we = 1'b1; pat_addr = 2'(j); pat_data = 2'(p[j]); mpat[j] = p[j];
      start = with_start && (j == TP - 1);
    end
    @(negedge clk);
    pat_we = 1'b0; start = 1'b0;
    if (with_start) begin
      check("pat_we_over_start_busy", 64'(busy), 64'(0));
      check("pat_we_over_start_state", 64'(state), 64'(0));
    end
  endtask

  task automatic start_run();
    hist.delete();
    best_v = 1'b0; best_i = 0; best_d = 63;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic send(input int sym, input bit last);
    int guard = 0;
    @(negedge clk);
    txt_valid = 1'b1; txt_data = 2'(sym); txt_last = last;
    while (!txt_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("txt_ready_wait", 64'(txt_ready), 64'(1));
    if (txt_ready) model_accept(sym, cyc);
    @(posedge clk);
    #1;
    txt_valid = 1'b0; txt_last = 1'b0;
  endtask

  task automatic finish_run();
    int  g = 0;
    bit  seen = 1'b0;
    while (g < 60 && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      g++;
    end
    check("done_pulse", 64'(seen), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
`ifdef EDIT_DISTANCE_BEST_EN
    check("best_valid", 64'(best_valid), 64'(best_v));
    if (best_v) begin
      check("best_idx", 64'(best_idx), 64'(best_i));
      check("best_dist", 64'(best_dist), 64'(best_d));
    end
`else
    check("best_valid_tied", 64'(best_valid), 64'(0));
    check("best_idx_tied", 64'(best_idx), 64'(0));
    check("best_dist_tied", 64'(best_dist), 64'(63));
`endif
  endtask

  task automatic run_stream(input int max_gap);
    start_run();
    for (int i = 0; i < stim.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send(stim[i], i == stim.size() - 1);
    end
    finish_run();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txt_ready"}, 64'(txt_ready), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check({tag, "_res_idx"}, 64'(res_idx), 64'(0));
    check({tag, "_res_dist"}, 64'(res_dist), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_best_valid"}, 64'(best_valid), 64'(0));
    check({tag, "_best_idx"}, 64'(best_idx), 64'(0));
    check({tag, "_best_dist"}, 64'(best_dist), 64'(63));
    check({tag, "_state"}, 64'(state), 64'(0));
    check({tag, "_sat_res_valid"}, 64'(s_res_valid), 64'(0));
    check({tag, "_sat_best_dist"}, 64'(s_best_dist), 64'(3));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid || s_res_valid) check("sat_valid_align", 64'(s_res_valid), 64'(res_valid));
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(res_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("res_cycle", 64'(cyc), 64'(mon_e[71:40]));
          check("res_idx", 64'(res_idx), 64'(mon_e[39:8]));
          check("res_dist", 64'(res_dist), 64'(mon_e[7:2]));
          check("sat_res_idx", 64'(s_res_idx), 64'(mon_e[39:8]));
          check("sat_res_dist", 64'(s_res_dist), 64'(mon_e[1:0]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; pat_we = 1'b0; pat_addr = '0; pat_data = '0; start = 1'b0;
    txt_valid = 1'b0; txt_data = '0; txt_last = 1'b0;
    for (int j = 0; j < TP; j++) mpat[j] = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    load_pattern(0, 1, 2, 3, 1'b1);

    stim = '{0, 1, 2, 3};          run_stream(0);
    stim = '{0, 1, 2, 0};          run_stream(0);
    stim = '{3, 3, 3, 3};          run_stream(1);
    stim = '{3, 3, 0, 1, 2, 3, 0}; run_stream(3);
    stim = '{1, 2, 3};             run_stream(2);

    load_pattern(0, 0, 0, 0, 1'b0);
    stim = '{3, 3, 3, 3};          run_stream(0);

    for (int r = 0; r < 5; r++) begin
      load_pattern($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      stim.delete();
      for (int i = 0; i < $urandom_range(5, 16); i++) stim.push_back($urandom_range(0, 3));
      run_stream(2);
    end

    // Reset in the middle of a stream, with results in flight.
    load_pattern(0, 1, 2, 3, 1'b0);
    start_run();
    for (int i = 0; i < 6; i++) send($urandom_range(0, 3), 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    load_pattern(2, 0, 1, 3, 1'b0);
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back($urandom_range(0, 3));
    run_stream(1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
